// File: rtl/soc_system_led_ctrl.sv
// Avalon-MM LED controller: register file with atomic set/clear,
// per-channel blink from a prescaled phase, and global PWM brightness.
module soc_system_led_ctrl #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b1}},
  parameter int                PRESCALE_W  = 16,
  parameter int                PWM_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      blink_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PWM_W-1:0]      duty_q;
  logic [PWM_W-1:0]      pwm_cnt;
  logic                  phase;
  logic [WIDTH-1:0]      out_q;

  logic             wr;
  logic             period_wr;
  logic             tick;
  logic             pwm_on;
  logic [WIDTH-1:0] nxt;
  logic             unused_wdata;

  assign wr        = chipselect && !write_n;
  assign period_wr = wr && (address == 3'd4);
  // a PERIOD write restarts the count and swallows that cycle's tick
  assign tick      = (pre_cnt == '0) && !period_wr;
  assign pwm_on    = (&duty_q) || (pwm_cnt < duty_q);

  always_comb begin
    nxt = '0;
    for (int i = 0; i < WIDTH; i++)
      nxt[i] = data_q[i] & (blink_q[i] ? phase : 1'b1) & pwm_on;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= '1;
      pre_cnt  <= '1;
      duty_q   <= '1;
      pwm_cnt  <= '0;
      phase    <= 1'b1;
      out_q    <= RESET_VALUE;
    end else begin
      if (wr) begin
        case (address)
          3'd0: data_q   <= writedata[WIDTH-1:0];
          3'd1: data_q   <= data_q | writedata[WIDTH-1:0];
          3'd2: data_q   <= data_q & ~writedata[WIDTH-1:0];
          3'd3: blink_q  <= writedata[WIDTH-1:0];
          3'd4: period_q <= writedata[PRESCALE_W-1:0];
          3'd5: duty_q   <= writedata[PWM_W-1:0];
          default: ;
        endcase
      end
      if (period_wr)
        pre_cnt <= writedata[PRESCALE_W-1:0];
      else if (pre_cnt == '0)
        pre_cnt <= period_q;
      else
        pre_cnt <= pre_cnt - 1'b1;
      if (tick)
        phase <= ~phase;
      pwm_cnt <= pwm_cnt + 1'b1;
      out_q   <= nxt;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(data_q);
      3'd3:    readdata = 32'(blink_q);
      3'd4:    readdata = 32'(period_q);
      3'd5:    readdata = 32'(duty_q);
      3'd6:    readdata = 32'(out_q);
      default: readdata = '0;
    endcase
  end

  assign out_port     = out_q;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_soc_system_led_ctrl.sv
// Directed bench for soc_system_led_ctrl: register table plus
// blink, PWM, period-rewrite and reset corner sequences.
module tb_soc_system_led_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks   = 0;
  int failures = 0;

  soc_system_led_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] val;
  } vec_t;

  localparam int N = 25;
  vec_t tbl [0:N-1];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // write lands on the next rising edge; returns 1ns after that edge
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input string name, input logic [2:0] a,
                        input logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic p0;
    int   hi;
    int   bad;

    tbl[0]  = '{1'b0, 3'd0, 32'h0000_00FF};
    tbl[1]  = '{1'b0, 3'd6, 32'h0000_00FF};
    tbl[2]  = '{1'b0, 3'd3, 32'h0000_0000};
    tbl[3]  = '{1'b0, 3'd4, 32'h0000_FFFF};
    tbl[4]  = '{1'b0, 3'd5, 32'h0000_00FF};
    tbl[5]  = '{1'b0, 3'd7, 32'h0000_0000};
    tbl[6]  = '{1'b1, 3'd0, 32'h0000_000F};
    tbl[7]  = '{1'b1, 3'd1, 32'h0000_0030};
    tbl[8]  = '{1'b1, 3'd2, 32'h0000_0003};
    tbl[9]  = '{1'b0, 3'd0, 32'h0000_003C};
    tbl[10] = '{1'b0, 3'd1, 32'h0000_0000};
    tbl[11] = '{1'b0, 3'd2, 32'h0000_0000};
    tbl[12] = '{1'b1, 3'd0, 32'hFFFF_FF5A};
    tbl[13] = '{1'b0, 3'd0, 32'h0000_005A};
    tbl[14] = '{1'b1, 3'd6, 32'h0000_0000};
    tbl[15] = '{1'b0, 3'd6, 32'h0000_005A};
    tbl[16] = '{1'b1, 3'd7, 32'hFFFF_FFFF};
    tbl[17] = '{1'b0, 3'd7, 32'h0000_0000};
    tbl[18] = '{1'b1, 3'd4, 32'h0001_2345};
    tbl[19] = '{1'b0, 3'd4, 32'h0000_2345};
    tbl[20] = '{1'b1, 3'd5, 32'h0000_01FF};
    tbl[21] = '{1'b0, 3'd5, 32'h0000_00FF};
    tbl[22] = '{1'b1, 3'd3, 32'h0000_0F00};
    tbl[23] = '{1'b0, 3'd3, 32'h0000_0000};
    tbl[24] = '{1'b1, 3'd4, 32'h0000_FFFF};

    reset = 1'b1; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out_port", 32'(out_port), 32'hFF);

    for (int i = 0; i < N; i++) begin
      if (tbl[i].wr)
        bus_wr(tbl[i].addr, tbl[i].val);
      else
        bus_rd($sformatf("tbl%0d_a%0d", i, tbl[i].addr),
               tbl[i].addr, tbl[i].val);
    end

    // set/clear: out_port follows one edge after the CLEAR write
    bus_wr(3'd0, 32'h0F);
    bus_wr(3'd1, 32'h30);
    bus_wr(3'd2, 32'h03);
    chk("sc_out_before", 32'(out_port), 32'h3F);
    @(posedge clk); #1;
    chk("sc_out_after", 32'(out_port), 32'h3C);

    // blink: PERIOD=3 -> phase toggles every 4 edges after the write,
    // out_port shows it one edge later
    bus_wr(3'd0, 32'hFF);
    bus_wr(3'd3, 32'h01);
    bus_wr(3'd4, 32'd3);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 1) p0 = out_port[0];
      chk($sformatf("blink_b0_k%0d", k), 32'(out_port[0]),
          32'(p0 ^ (((k - 1) / 4) % 2 == 1)));
      chk($sformatf("blink_hi_k%0d", k), 32'(out_port[7:1]), 32'h7F);
    end

    // period rewrite with pre_cnt at 50
    bus_wr(3'd4, 32'd100);
    repeat (50) @(posedge clk);
    bus_wr(3'd4, 32'd2);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) p0 = out_port[0];
      chk($sformatf("rewr_b0_k%0d", k), 32'(out_port[0]),
          32'(p0 ^ (((k - 1) / 3) % 2 == 1)));
    end

    // reset mid-blink
    @(negedge clk);
    reset = 1'b1; address = 3'd3;
    #1;
    chk("rst_out_port", 32'(out_port), 32'hFF);
    chk("rst_blink_en", readdata, 32'h0);
    address = 3'd7;
    #1;
    chk("rst_addr7", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_out", 32'(out_port), 32'hFF);
    bus_rd("post_rst_a7", 3'd7, 32'h0);
    bus_rd("post_rst_period", 3'd4, 32'hFFFF);

    // PWM duty 64 over one full 256-cycle window
    bus_wr(3'd5, 32'd64);
    @(posedge clk); #1;
    hi = 0; bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (out_port == 8'hFF) hi++;
      else if (out_port != 8'h00) bad++;
      @(posedge clk); #1;
    end
    chk("pwm64_high", hi, 64);
    chk("pwm64_shape", bad, 0);

    bus_wr(3'd5, 32'd0);
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (out_port != 8'h00) bad++;
      @(posedge clk); #1;
    end
    chk("pwm0_off", bad, 0);

    bus_wr(3'd0, 32'hA5);
    bus_wr(3'd5, 32'hFF);
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (out_port != 8'hA5) bad++;
      @(posedge clk); #1;
    end
    chk("pwmff_on", bad, 0);
    bus_rd("final_out_reg", 3'd6, 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
